// File: rtl/fetch_stage_pkg.sv
// Shared constants and FSM encoding for the instruction-fetch front end.
// Optional fetch counter is enabled by defining FETCH_PERF_EN.
package fetch_stage_pkg;

  localparam int          OPCODE_W = 6;
  localparam logic [5:0]  OP_HALT  = 6'b111111;
  localparam logic [31:0] NOP_INST = 32'h0000_0000;

  typedef enum logic [1:0] {
    FS_LOAD = 2'b00,
    FS_RUN  = 2'b01,
    FS_HALT = 2'b10
  } fs_state_e;

endpackage

// File: rtl/fetch_stage_inst_mem.sv
// Instruction memory: one synchronous write port, one asynchronous read port.
// Loaded by the bench while the fetch stage sits in LOAD.
module inst_mem #(
  parameter int PCW   = 8,
  parameter int ISIZE = 32
) (
  input  logic             clk,
  input  logic             wen_i,
  input  logic [PCW-1:0]   waddr_i,
  input  logic [ISIZE-1:0] wdata_i,
  input  logic [PCW-1:0]   raddr_i,
  output logic [ISIZE-1:0] rdata_o
);

  logic [ISIZE-1:0] mem_q [2**PCW];

  // NOTE: the array has no reset; contents survive rst so a program can be reloaded selectively.
  always_ff @(posedge clk) begin
    if (wen_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/fetch_stage.sv
// Fetch stage: LOAD/RUN/HALT FSM, PC, IF/ID register and optional fetch counter.
// Define FETCH_PERF_EN to build the saturating fetch_count register.
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter int PCW   = 8,
  parameter int ISIZE = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             imem_wen,
  input  logic [PCW-1:0]   imem_waddr,
  input  logic [ISIZE-1:0] imem_wdata,
  input  logic             stall,
  input  logic             redirect_en,
  input  logic [PCW-1:0]   redirect_pc,
  output logic [ISIZE-1:0] inst,
  output logic             inst_valid,
  output logic [PCW-1:0]   pc_out,
  output logic             halted,
  output logic [31:0]      fetch_count
);

  localparam logic [ISIZE-1:0] NOP = ISIZE'(NOP_INST);

  fs_state_e        state_q, state_d;
  logic [PCW-1:0]   pc_q, pc_d;
  logic [PCW-1:0]   pc_out_q, pc_out_d;
  logic [ISIZE-1:0] inst_q, inst_d;
  logic             valid_q, valid_d;
  logic [ISIZE-1:0] imem_rdata;
  logic             halt_word;

  inst_mem #(.PCW(PCW), .ISIZE(ISIZE)) u_inst_mem (
    .clk     (clk),
    .wen_i   (imem_wen && (state_q == FS_LOAD)),
    .waddr_i (imem_waddr),
    .wdata_i (imem_wdata),
    .raddr_i (pc_q),
    .rdata_o (imem_rdata)
  );

  assign halt_word = (imem_rdata[ISIZE-1 -: OPCODE_W] == OP_HALT);

  // NOTE: every always_comb output gets a hold default first so no path can infer a latch.
  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    pc_out_d = pc_out_q;
    inst_d   = inst_q;
    valid_d  = valid_q;
    unique case (state_q)
      FS_LOAD: begin
        inst_d  = NOP;
        valid_d = 1'b0;
        if (start) begin
          state_d = FS_RUN;
          pc_d    = '0;
        end
      end
      FS_RUN: begin
        if (redirect_en) begin
          pc_d    = redirect_pc;
          inst_d  = NOP;
          valid_d = 1'b0;
        end else if (stall) begin
          // hold everything
        end else if (halt_word) begin
          // the halt word itself is never issued and the PC parks on it
          inst_d  = NOP;
          valid_d = 1'b0;
          state_d = FS_HALT;
        end else begin
          inst_d   = imem_rdata;
          pc_out_d = pc_q;
          valid_d  = 1'b1;
          pc_d     = pc_q + 1'b1;
        end
      end
      FS_HALT: begin
        inst_d  = NOP;
        valid_d = 1'b0;
        if (start) begin
          state_d = FS_RUN;
          pc_d    = '0;
        end
      end
      default: begin
        state_d = FS_LOAD;
        inst_d  = NOP;
        valid_d = 1'b0;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= FS_LOAD;
      pc_q     <= '0;
      pc_out_q <= '0;
      inst_q   <= NOP;
      valid_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      pc_out_q <= pc_out_d;
      inst_q   <= inst_d;
      valid_q  <= valid_d;
    end
  end

  assign inst       = inst_q;
  assign inst_valid = valid_q;
  assign pc_out     = pc_out_q;
  assign halted     = (state_q == FS_HALT);

`ifdef FETCH_PERF_EN
  logic        issue;
  logic [31:0] fetch_count_q;

  assign issue = (state_q == FS_RUN) && !redirect_en && !stall && !halt_word;

  always_ff @(posedge clk) begin
    if (!rst) begin
      fetch_count_q <= '0;
    end else if (issue && (fetch_count_q != 32'hFFFF_FFFF)) begin
      fetch_count_q <= fetch_count_q + 32'd1;
    end
  end

  assign fetch_count = fetch_count_q;
`else
  assign fetch_count = 32'h0;
`endif

endmodule
